// File: rtl/mips_defs.sv
// Shared MIPS encodings: opcodes, functs, controller states and datapath selects.
package mips_defs;

  localparam int unsigned INS_W   = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

  // R-type functs
  localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [OP_W-1:0] FN_JR   = 6'b001000;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_LUI = 2'd3;

  // Next-PC source select
  localparam logic [1:0] JS_SEQ  = 2'd0;
  localparam logic [1:0] JS_JUMP = 2'd1;
  localparam logic [1:0] JS_JR   = 2'd2;

  // Register-file destination select
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  // Register-file write-data select
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

  // Controller states
  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXE_R    = 4'd2,
    S_WB_R     = 4'd3,
    S_EXE_I    = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_WB_LW    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  // One-hot instruction class
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic ill;
  } ins_cls_t;

  // Full set of datapath controls
  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       npc_sel;
    logic [1:0] jump_sel;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       ext_op;
    logic       mem_we;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction/flag in, control strobes out.
interface mc_ctrl_if;
  import mips_defs::*;

  logic [INS_W-1:0] ins;
  logic             zero;
  logic             pc_we;
  logic             ir_we;
  logic             nPC_sel;
  logic [1:0]       jump_sel;
  logic             reg_we;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             ext_op;
  logic             mem_we;
  logic             instr_done;
  logic             illegal;

  modport master (
    input  ins, zero,
    output pc_we, ir_we, nPC_sel, jump_sel, reg_we, reg_dst, mem_to_reg,
           alu_src, alu_op, ext_op, mem_we, instr_done, illegal
  );

  modport slave (
    output ins, zero,
    input  pc_we, ir_we, nPC_sel, jump_sel, reg_we, reg_dst, mem_to_reg,
           alu_src, alu_op, ext_op, mem_we, instr_done, illegal
  );
endinterface

// File: rtl/mc_ctrl_dec.sv
// Combinational opcode/funct decode into a one-hot instruction class.
module mc_ctrl_dec
  import mips_defs::*;
(
  input  logic [OP_W-1:0] op_i,
  input  logic [OP_W-1:0] funct_i,
  output ins_cls_t        cls_c_o
);

  // Anything not recognised lands in the illegal class
  always_comb begin
    cls_c_o = '0;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: cls_c_o.addu = 1'b1;
          FN_SUBU: cls_c_o.subu = 1'b1;
          FN_JR:   cls_c_o.jr   = 1'b1;
          default: cls_c_o.ill  = 1'b1;
        endcase
      end
      OP_ORI:  cls_c_o.ori = 1'b1;
      OP_LUI:  cls_c_o.lui = 1'b1;
      OP_LW:   cls_c_o.lw  = 1'b1;
      OP_SW:   cls_c_o.sw  = 1'b1;
      OP_BEQ:  cls_c_o.beq = 1'b1;
      OP_J:    cls_c_o.j   = 1'b1;
      OP_JAL:  cls_c_o.jal = 1'b1;
      default: cls_c_o.ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller. Controls are registered from the next
// state and next latched class, so they are pure Moore outputs of the FSM.
module mc_ctrl
  import mips_defs::*;
(
  input  logic       clock,
  input  logic       reset,
  mc_ctrl_if.master  bus
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [OP_W-1:0]   funct_q, funct_d;
  ins_cls_t          cls_q, cls_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              unused_in_c;

  // Only the opcode/funct fields matter here; zero is consumed by the PC datapath
  assign unused_in_c = ^{bus.ins[INS_W-OP_W-1:OP_W], bus.zero};

  // Opcode/funct are captured only on the edge leaving FETCH
  always_comb begin
    op_d    = op_q;
    funct_d = funct_q;
    if (state_q == S_FETCH) begin
      op_d    = bus.ins[INS_W-1 -: OP_W];
      funct_d = bus.ins[OP_W-1:0];
    end
  end

  mc_ctrl_dec u_dec (
    .op_i    (op_d),
    .funct_i (funct_d),
    .cls_c_o (cls_d)
  );

  // State, latched instruction fields and registered controls
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_FETCH;
      op_q         <= '0;
      funct_q      <= '0;
      cls_q        <= '0;
      ctrl_q       <= '0;
      ctrl_q.ir_we <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      cls_q   <= cls_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Next state, then the controls belonging to that next state
  always_comb begin
    state_d = state_q;
    ctrl_d  = '0;

    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (cls_q.addu || cls_q.subu)               state_d = S_EXE_R;
        else if (cls_q.ori || cls_q.lui)            state_d = S_EXE_I;
        else if (cls_q.lw || cls_q.sw)              state_d = S_MEM_ADDR;
        else if (cls_q.beq)                         state_d = S_BRANCH;
        else if (cls_q.j || cls_q.jal || cls_q.jr)  state_d = S_JUMP;
        else                                        state_d = S_FETCH;
      end
      S_EXE_R:    state_d = S_WB_R;
      S_EXE_I:    state_d = S_WB_I;
      S_MEM_ADDR: state_d = cls_q.sw ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = S_WB_LW;
      default:    state_d = S_FETCH;
    endcase

    case (state_d)
      S_FETCH: ctrl_d.ir_we = 1'b1;
      S_DECODE: begin
        // Unsupported encodings retire here as a nop
        if (cls_d.ill) begin
          ctrl_d.pc_we      = 1'b1;
          ctrl_d.instr_done = 1'b1;
          ctrl_d.illegal    = 1'b1;
        end
      end
      S_EXE_R: begin
        ctrl_d.alu_op = cls_d.subu ? ALU_SUB : ALU_ADD;
      end
      S_WB_R: begin
        ctrl_d.alu_op     = cls_d.subu ? ALU_SUB : ALU_ADD;
        ctrl_d.reg_we     = 1'b1;
        ctrl_d.reg_dst    = RD_RD;
        ctrl_d.mem_to_reg = M2R_ALU;
        ctrl_d.pc_we      = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_EXE_I: begin
        ctrl_d.alu_src = 1'b1;
        ctrl_d.alu_op  = cls_d.lui ? ALU_LUI : ALU_OR;
      end
      S_WB_I: begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.alu_op     = cls_d.lui ? ALU_LUI : ALU_OR;
        ctrl_d.reg_we     = 1'b1;
        ctrl_d.reg_dst    = RD_RT;
        ctrl_d.mem_to_reg = M2R_ALU;
        ctrl_d.pc_we      = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl_d.alu_src = 1'b1;
        ctrl_d.ext_op  = 1'b1;
        ctrl_d.alu_op  = ALU_ADD;
      end
      S_MEM_WR: begin
        ctrl_d.mem_we     = 1'b1;
        ctrl_d.pc_we      = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_WB_LW: begin
        ctrl_d.reg_we     = 1'b1;
        ctrl_d.reg_dst    = RD_RT;
        ctrl_d.mem_to_reg = M2R_MEM;
        ctrl_d.pc_we      = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_BRANCH: begin
        // Target choice on zero is made in the PC datapath, not here
        ctrl_d.alu_op     = ALU_SUB;
        ctrl_d.npc_sel    = 1'b1;
        ctrl_d.pc_we      = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pc_we      = 1'b1;
        ctrl_d.instr_done = 1'b1;
        ctrl_d.jump_sel   = cls_d.jr ? JS_JR : JS_JUMP;
        if (cls_d.jal) begin
          ctrl_d.reg_we     = 1'b1;
          ctrl_d.reg_dst    = RD_RA;
          ctrl_d.mem_to_reg = M2R_PC4;
        end
      end
      default: ctrl_d = '0;
    endcase
  end

  assign bus.pc_we      = ctrl_q.pc_we;
  assign bus.ir_we      = ctrl_q.ir_we;
  assign bus.nPC_sel    = ctrl_q.npc_sel;
  assign bus.jump_sel   = ctrl_q.jump_sel;
  assign bus.reg_we     = ctrl_q.reg_we;
  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.alu_src    = ctrl_q.alu_src;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.ext_op     = ctrl_q.ext_op;
  assign bus.mem_we     = ctrl_q.mem_we;
  assign bus.instr_done = ctrl_q.instr_done;
  assign bus.illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class cycle by cycle.
module tb_mc_ctrl;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  mc_ctrl_if bus ();

  mc_ctrl u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Pack expected controls: pc ir npc js rw rd m2r asrc aop ext mw done ill
  function automatic logic [16:0] mk(input logic pc, input logic ir, input logic npc,
                                     input logic [1:0] js, input logic rw,
                                     input logic [1:0] rd, input logic [1:0] m2r,
                                     input logic asrc, input logic [1:0] aop,
                                     input logic ext, input logic mw,
                                     input logic done, input logic ill);
    return {pc, ir, npc, js, rw, rd, m2r, asrc, aop, ext, mw, done, ill};
  endfunction

  localparam logic [16:0] V_IR = mk(0,1,0, 2'd0,0,2'd0,2'd0, 0,2'd0,0,0, 0,0);
  localparam logic [16:0] V_0  = 17'd0;

  task automatic chk(input string tag, input logic [16:0] exp_v);
    logic [16:0] obs_v;
    obs_v = {bus.pc_we, bus.ir_we, bus.nPC_sel, bus.jump_sel, bus.reg_we,
             bus.reg_dst, bus.mem_to_reg, bus.alu_src, bus.alu_op, bus.ext_op,
             bus.mem_we, bus.instr_done, bus.illegal};
    n_cmp++;
    assert (obs_v === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs_v, exp_v);
    end
  endtask

  // Advance one clock and sample just after the edge
  task automatic tk(input string tag, input logic [16:0] exp_v);
    @(posedge clock);
    #1;
    chk(tag, exp_v);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    bus.ins  = 32'h0;
    bus.zero = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("reset_fetch", V_IR);

    // addu: F D EXE_R WB_R; ins garbage after FETCH must be ignored
    reset   = 1'b0;
    bus.ins = 32'h00851021;
    tk("addu_dec", V_0);
    bus.ins = 32'hFC000000;
    tk("addu_exe", V_0);
    tk("addu_wb",  mk(1,0,0, 2'd0,1,2'd1,2'd0, 0,2'd0,0,0, 1,0));
    tk("addu_f",   V_IR);

    // subu
    bus.ins = 32'h00851023;
    tk("subu_dec", V_0);
    tk("subu_exe", mk(0,0,0, 2'd0,0,2'd0,2'd0, 0,2'd1,0,0, 0,0));
    tk("subu_wb",  mk(1,0,0, 2'd0,1,2'd1,2'd0, 0,2'd1,0,0, 1,0));
    tk("subu_f",   V_IR);

    // ori
    bus.ins = 32'h34850010;
    tk("ori_dec", V_0);
    tk("ori_exe", mk(0,0,0, 2'd0,0,2'd0,2'd0, 1,2'd2,0,0, 0,0));
    tk("ori_wb",  mk(1,0,0, 2'd0,1,2'd0,2'd0, 1,2'd2,0,0, 1,0));
    tk("ori_f",   V_IR);

    // lui
    bus.ins = 32'h3C050010;
    tk("lui_dec", V_0);
    tk("lui_exe", mk(0,0,0, 2'd0,0,2'd0,2'd0, 1,2'd3,0,0, 0,0));
    tk("lui_wb",  mk(1,0,0, 2'd0,1,2'd0,2'd0, 1,2'd3,0,0, 1,0));
    tk("lui_f",   V_IR);

    // lw: 5 cycles
    bus.ins = 32'h8C820004;
    tk("lw_dec",  V_0);
    tk("lw_addr", mk(0,0,0, 2'd0,0,2'd0,2'd0, 1,2'd0,1,0, 0,0));
    tk("lw_rd",   V_0);
    tk("lw_wb",   mk(1,0,0, 2'd0,1,2'd0,2'd1, 0,2'd0,0,0, 1,0));
    tk("lw_f",    V_IR);

    // sw: 4 cycles, mem_we only with pc_we
    bus.ins = 32'hAC820004;
    tk("sw_dec",  V_0);
    tk("sw_addr", mk(0,0,0, 2'd0,0,2'd0,2'd0, 1,2'd0,1,0, 0,0));
    tk("sw_wr",   mk(1,0,0, 2'd0,0,2'd0,2'd0, 0,2'd0,0,1, 1,0));
    tk("sw_f",    V_IR);

    // beq with zero=1 then zero=0: identical controls
    bus.ins  = 32'h10850003;
    bus.zero = 1'b1;
    tk("beq1_dec", V_0);
    tk("beq1_br",  mk(1,0,1, 2'd0,0,2'd0,2'd0, 0,2'd1,0,0, 1,0));
    tk("beq1_f",   V_IR);
    bus.zero = 1'b0;
    tk("beq0_dec", V_0);
    tk("beq0_br",  mk(1,0,1, 2'd0,0,2'd0,2'd0, 0,2'd1,0,0, 1,0));
    tk("beq0_f",   V_IR);

    // j
    bus.ins = 32'h08000010;
    tk("j_dec",  V_0);
    tk("j_jump", mk(1,0,0, 2'd1,0,2'd0,2'd0, 0,2'd0,0,0, 1,0));
    tk("j_f",    V_IR);

    // jal
    bus.ins = 32'h0C000010;
    tk("jal_dec",  V_0);
    tk("jal_jump", mk(1,0,0, 2'd1,1,2'd2,2'd2, 0,2'd0,0,0, 1,0));
    tk("jal_f",    V_IR);

    // jr
    bus.ins = 32'h03E00008;
    tk("jr_dec",  V_0);
    tk("jr_jump", mk(1,0,0, 2'd2,0,2'd0,2'd0, 0,2'd0,0,0, 1,0));
    tk("jr_f",    V_IR);

    // illegal opcode; ins change during DECODE has no effect
    bus.ins = 32'hFC000000;
    tk("ill_dec", mk(1,0,0, 2'd0,0,2'd0,2'd0, 0,2'd0,0,0, 1,1));
    bus.ins = 32'h00851021;
    tk("ill_f",   V_IR);

    // illegal R-type funct (sll encoding)
    bus.ins = 32'h00000000;
    tk("illfn_dec", mk(1,0,0, 2'd0,0,2'd0,2'd0, 0,2'd0,0,0, 1,1));
    tk("illfn_f",   V_IR);

    // lw aborted by a 2-cycle reset in DECODE, then sw runs normally
    bus.ins = 32'h8C820004;
    tk("abort_dec", V_0);
    reset = 1'b1;
    tk("abort_rst1", V_IR);
    tk("abort_rst2", V_IR);
    reset   = 1'b0;
    bus.ins = 32'hAC820004;
    tk("post_dec",  V_0);
    tk("post_addr", mk(0,0,0, 2'd0,0,2'd0,2'd0, 1,2'd0,1,0, 0,0));
    tk("post_wr",   mk(1,0,0, 2'd0,0,2'd0,2'd0, 0,2'd0,0,1, 1,0));
    tk("post_f",    V_IR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main controller, directly downstream of the instruction fetch unit.
- Consumes the 32-bit instruction word and the ALU zero flag.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states.
- Drives PC-update selects (nPC_sel, jump_sel), the PC write enable, and all datapath controls.

Parameters:
- INS_W, 32, instruction width.
- OP_W, 6, opcode/funct field width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ins  input  32  instruction word from the fetch unit.
- zero  input  1  ALU zero flag; valid in BRANCH state.
- pc_we  output  1  PC write enable; one pulse per instruction, in its final state.
- ir_we  output  1  instruction latch enable; high only in FETCH.
- nPC_sel  output  1  1 = branch target if zero.
- jump_sel  output  2  0 = sequential, 1 = j/jal target, 2 = jr register.
- reg_we  output  1  register file write enable.
- reg_dst  output  2  0 = rt, 1 = rd, 2 = $31.
- mem_to_reg  output  2  0 = ALU, 1 = memory, 2 = PC+4.
- alu_src  output  1  0 = rt, 1 = extended immediate.
- alu_op  output  2  0 = add, 1 = sub, 2 = or, 3 = lui shift.
- ext_op  output  1  0 = zero-extend, 1 = sign-extend.
- mem_we  output  1  data memory write enable.
- instr_done  output  1  one-cycle pulse coincident with pc_we.
- illegal  output  1  one-cycle pulse on unsupported opcode/funct.

Behaviour:
- Reset:
  - Synchronous reset forces state = FETCH and clears the latched opcode/funct to 0.
  - During reset and in the following cycle, every output is 0 except ir_we, which follows FETCH and is 1 in the cycle after reset.
  - Reset asserted mid-instruction aborts it: no pc_we, reg_we or mem_we is issued afterwards.
- Instruction latch: opcode = ins[31:26] and funct = ins[5:0] are latched on the clock edge leaving FETCH. DECODE and later states use only the latched copy; ins changes after FETCH are ignored.
- Supported instructions:
  - R-type (op 000000) with funct 100001 addu, 100011 subu, 001000 jr.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- States and transitions:
  - FETCH -> DECODE, always.
  - DECODE, by latched opcode/funct:
    - addu/subu -> EXE_R.
    - ori/lui -> EXE_I.
    - lw/sw -> MEM_ADDR.
    - beq -> BRANCH.
    - j/jal/jr -> JUMP.
    - anything else -> FETCH, with pc_we = 1, jump_sel = 0, illegal = 1, instr_done = 1; treated as a nop.
  - EXE_R -> WB_R: alu_src = 0; alu_op = 0 for addu, 1 for subu.
  - EXE_I -> WB_I: alu_src = 1, ext_op = 0; alu_op = 2 for ori, 3 for lui.
  - MEM_ADDR: alu_src = 1, ext_op = 1, alu_op = 0. Goes to MEM_RD for lw, MEM_WR for sw.
  - MEM_RD -> WB_LW.
  - MEM_WR -> FETCH: mem_we = 1, pc_we = 1.
  - WB_R -> FETCH: reg_we = 1, reg_dst = 1, mem_to_reg = 0, pc_we = 1. The ALU controls of EXE_R are held.
  - WB_I -> FETCH: reg_we = 1, reg_dst = 0, mem_to_reg = 0, pc_we = 1. The ALU controls of EXE_I are held.
  - WB_LW -> FETCH: reg_we = 1, reg_dst = 0, mem_to_reg = 1, pc_we = 1.
  - BRANCH -> FETCH: alu_src = 0, alu_op = 1, nPC_sel = 1, pc_we = 1. The PC datapath chooses the target on zero; the controller does not gate pc_we on zero.
  - JUMP -> FETCH, pc_we = 1:
    - j: jump_sel = 1.
    - jal: jump_sel = 1, reg_we = 1, reg_dst = 2, mem_to_reg = 2.
    - jr: jump_sel = 2.
- Signal defaults: any control not listed for a state is 0.
- Output timing:
  - All outputs are Moore functions of state plus latched opcode/funct: no combinational path from ins or zero to outputs.
  - Exception: nPC_sel is fixed at 1 in BRANCH regardless of zero.
- Latency, FETCH to pc_we inclusive:
  - addu/subu/ori/lui/sw: 4 cycles.
  - lw: 5 cycles.
  - beq/j/jal/jr: 3 cycles.
  - illegal: 2 cycles.
- Invariants:
  - pc_we and mem_we are never both high outside MEM_WR.
  - reg_we and mem_we are never simultaneously 1.
  - Exactly one pc_we per completed instruction.

Decomposition:
- Shared package mips_defs:
  - Opcode and funct constants.
  - State encoding: 4-bit localparams, 12 states.
  - alu_op, jump_sel, reg_dst and mem_to_reg encodings.
  - These are reused by the datapath and the ALU.
- Optional sub-module mc_ctrl_dec: combinational decode of the latched opcode/funct into an instruction-class one-hot, used by the DECODE transition logic.

Test Plan:
- Reset: hold reset 2 cycles mid-stream, then release -> next cycle FETCH with ir_we = 1; all other outputs 0; no spurious pc_we.
- addu: ins = 0x00851021 -> states F, D, EXE_R, WB_R. pc_we high only in cycle 4, with reg_we = 1, reg_dst = 1, alu_op = 0.
- lw then sw:
  - ins = 0x8C820004 -> 5 cycles; WB_LW shows mem_to_reg = 1.
  - ins = 0xAC820004 -> 4 cycles; mem_we = 1 only in MEM_WR, coincident with pc_we; reg_we stays 0.
- beq: ins = 0x10850003 with zero = 1, then with zero = 0 -> both take 3 cycles with nPC_sel = 1 and pc_we = 1 in BRANCH; outputs identical in both cases.
- jal/jr:
  - ins = 0x0C000010 -> JUMP with jump_sel = 1, reg_we = 1, reg_dst = 2, mem_to_reg = 2.
  - ins = 0x03E00008 -> jump_sel = 2, reg_we = 0.
- Illegal: ins = 0xFC000000 -> DECODE pulses illegal = 1 and pc_we = 1, then FETCH. Changing ins during DECODE does not alter the decode.
